// File: rtl/issue_ctl.sv
// issue_ctl: decode issue/interlock controller with a register-write scoreboard
// for r0..r13, an in-flight write limit and a halt/drain sequence.
// Optional build macro ISSUE_CTL_STATS_EN adds a saturating stall-cycle counter.
module issue_ctl #(
  parameter int unsigned MAX_INFLIGHT = 3,
  parameter int unsigned CNT_W        = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ins_valid,
  input  logic [3:0]       Ra,
  input  logic [3:0]       Rb,
  input  logic             Imb,
  input  logic [3:0]       Rc,
  input  logic             wr_en,
  input  logic             wb_valid,
  input  logic [3:0]       wb_rc,
  input  logic             halt_req,
  output logic             issue,
  output logic             stall,
  output logic [13:0]      pending,
  output logic [CNT_W-1:0] inflight,
  output logic             halted,
  output logic             wb_err,
  output logic [15:0]      stall_cnt
);

  typedef enum logic [1:0] {StRun, StDrain, StHalted} state_e;

  state_e           state_q;
  logic [13:0]      pending_q, pending_d;
  logic [CNT_W-1:0] inflight_q, inflight_d;
  logic             halted_q;
  logic             wb_err_q;

  // Indices 14 (pc) and 15 read as never-pending, so hazards need no range guard.
  logic [15:0] pend_ext;
  assign pend_ext = {2'b00, pending_q};

  logic rc_trk, wb_trk;
  logic raw_a, raw_b, waw, full;
  logic do_set, do_clr;
  logic [13:0] set_oh, clr_oh;

  assign rc_trk = (Rc < 4'd14);
  assign wb_trk = (wb_rc < 4'd14);
  assign raw_a  = pend_ext[Ra];
  assign raw_b  = ~Imb & pend_ext[Rb];
  assign waw    = wr_en & pend_ext[Rc];
  assign full   = wr_en & rc_trk & (inflight_q == CNT_W'(MAX_INFLIGHT));

  assign issue  = ins_valid & (state_q == StRun) & ~(raw_a | raw_b | waw | full);
  assign stall  = ins_valid & ~issue;

  assign do_set = issue & wr_en & rc_trk;
  assign do_clr = wb_valid & wb_trk & pend_ext[wb_rc];

  // Scoreboard next state: set on tracked issue, clear on retire of a pending bit.
  always_comb begin
    set_oh = '0;
    clr_oh = '0;
    for (int i = 0; i < 14; i++) begin
      set_oh[i] = do_set & (Rc == 4'(i));
      clr_oh[i] = do_clr & (wb_rc == 4'(i));
    end
    pending_d = (pending_q | set_oh) & ~clr_oh;
    unique case ({do_set, do_clr})
      2'b10:   inflight_d = inflight_q + CNT_W'(1);
      2'b01:   inflight_d = inflight_q - CNT_W'(1);
      default: inflight_d = inflight_q;
    endcase
  end

  // Scoreboard, in-flight count and sticky writeback error.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_q  <= '0;
      inflight_q <= '0;
      wb_err_q   <= 1'b0;
    end else begin
      pending_q  <= pending_d;
      inflight_q <= inflight_d;
      if (wb_valid && wb_trk && !pend_ext[wb_rc]) wb_err_q <= 1'b1;
    end
  end

  // Halt/drain FSM; DRAIN always lasts at least one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StRun;
      halted_q <= 1'b0;
    end else begin
      unique case (state_q)
        StRun: begin
          if (halt_req) state_q <= StDrain;
        end
        StDrain: begin
          if (!halt_req) begin
            state_q <= StRun;
          end else if (inflight_q == '0) begin
            state_q  <= StHalted;
            halted_q <= 1'b1;
          end
        end
        StHalted: begin
          if (!halt_req) begin
            state_q  <= StRun;
            halted_q <= 1'b0;
          end
        end
        default: begin
          state_q  <= StRun;
          halted_q <= 1'b0;
        end
      endcase
    end
  end

  assign pending  = pending_q;
  assign inflight = inflight_q;
  assign halted   = halted_q;
  assign wb_err   = wb_err_q;

`ifdef ISSUE_CTL_STATS_EN
  logic [15:0] stall_cnt_q;

  // Saturating count of stalled cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else if (stall && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

  assign stall_cnt = stall_cnt_q;
`else
  assign stall_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_issue_ctl.sv
// tb_issue_ctl: directed and randomized checks of issue_ctl against a
// behavioural model built from the register-hazard and halt rules.
module tb_issue_ctl;

  logic        clk = 1'b0;
  logic        rst;
  logic        ins_valid, Imb, wr_en, wb_valid, halt_req;
  logic [3:0]  Ra, Rb, Rc, wb_rc;
  logic        issue, stall, halted, wb_err;
  logic [13:0] pending;
  logic [3:0]  inflight;
  logic [15:0] stall_cnt;

  int errors = 0;
  int checks = 0;

  // Behavioural model: per-register busy flags, mode 0=run 1=drain 2=halted.
  bit          m_pend[14];
  int          m_mode;
  bit          m_err;
  int unsigned m_stalls;

  issue_ctl #(.MAX_INFLIGHT(3), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .ins_valid(ins_valid), .Ra(Ra), .Rb(Rb), .Imb(Imb),
    .Rc(Rc), .wr_en(wr_en), .wb_valid(wb_valid), .wb_rc(wb_rc), .halt_req(halt_req),
    .issue(issue), .stall(stall), .pending(pending), .inflight(inflight),
    .halted(halted), .wb_err(wb_err), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  function automatic int m_count();
    int n = 0;
    for (int i = 0; i < 14; i++) n += m_pend[i];
    return n;
  endfunction

  function automatic logic [13:0] m_vec();
    logic [13:0] v = '0;
    for (int i = 0; i < 14; i++) v[i] = m_pend[i];
    return v;
  endfunction

  function automatic bit busy(input logic [3:0] r);
    return (r < 14) && m_pend[r];
  endfunction

  function automatic bit m_issue();
    if (!ins_valid || m_mode != 0) return 0;
    if (busy(Ra)) return 0;
    if (!Imb && busy(Rb)) return 0;
    if (wr_en && busy(Rc)) return 0;
    if (wr_en && Rc < 14 && m_count() == 3) return 0;
    return 1;
  endfunction

  function automatic int unsigned m_stat();
`ifdef ISSUE_CTL_STATS_EN
    return m_stalls;
`else
    return 0;
`endif
  endfunction

  task automatic drive(input bit iv, input int ra, input int rb, input bit imb,
                       input int rc, input bit we, input bit wv, input int wr);
    ins_valid = iv; Ra = 4'(ra); Rb = 4'(rb); Imb = imb; Rc = 4'(rc); wr_en = we;
    wb_valid = wv; wb_rc = 4'(wr);
    #1;
  endtask

  // Advance one clock and move the model by the same rules.
  task automatic tick();
    bit ei;
    int cnt;
    ei  = m_issue();
    cnt = m_count();
    @(posedge clk);
    if (ins_valid && !ei && m_stalls != 32'hFFFF) m_stalls++;
    if (wb_valid && wb_rc < 14) begin
      if (m_pend[wb_rc]) m_pend[wb_rc] = 0;
      else m_err = 1;
    end
    if (ei && wr_en && Rc < 14) m_pend[Rc] = 1;
    case (m_mode)
      0: if (halt_req) m_mode = 1;
      1: if (!halt_req) m_mode = 0; else if (cnt == 0) m_mode = 2;
      default: if (!halt_req) m_mode = 0;
    endcase
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; halt_req = 1'b0;
    ins_valid = 0; Ra = 0; Rb = 0; Imb = 0; Rc = 0; wr_en = 0; wb_valid = 0; wb_rc = 0;
    @(posedge clk);
    #1 rst = 1'b0;
    foreach (m_pend[i]) m_pend[i] = 0;
    m_mode = 0; m_err = 0; m_stalls = 0;
  endtask

  task automatic test_reset();
    do_reset();
    drive(1, 1, 2, 0, 3, 1, 0, 0);
    checks++; if (pending !== 14'h0) begin errors++;
      $display("FAIL reset_pending got %h want 0", pending); end
    checks++; if (inflight !== 4'd0) begin errors++;
      $display("FAIL reset_inflight got %0d want 0", inflight); end
    checks++; if (halted !== 1'b0 || wb_err !== 1'b0) begin errors++;
      $display("FAIL reset_flags halted=%b wb_err=%b want 0 0", halted, wb_err); end
    checks++; if (stall_cnt !== 16'd0) begin errors++;
      $display("FAIL reset_stall_cnt got %0d want 0", stall_cnt); end
    checks++; if (issue !== 1'b1 || stall !== 1'b0) begin errors++;
      $display("FAIL reset_issue issue=%b stall=%b want 1 0", issue, stall); end
    tick();
    checks++; if (pending !== 14'h0008 || inflight !== 4'd1) begin errors++;
      $display("FAIL first_issue pending=%h inflight=%0d want 0008 1", pending, inflight); end
  endtask

  task automatic test_raw();
    // r3 still pending from test_reset; reader of r3 stalls until retire.
    for (int i = 0; i < 3; i++) begin
      drive(1, 3, 0, 1, 5, 0, (i == 2), 3);
      checks++; if (stall !== 1'b1 || issue !== 1'b0) begin errors++;
        $display("FAIL raw_stall cyc%0d stall=%b issue=%b want 1 0", i, stall, issue); end
      tick();
    end
    drive(1, 3, 0, 1, 5, 0, 0, 0);
    checks++; if (issue !== 1'b1 || inflight !== 4'd0) begin errors++;
      $display("FAIL raw_release issue=%b inflight=%0d want 1 0", issue, inflight); end
    tick();
  endtask

  task automatic test_full();
    do_reset();
    for (int r = 1; r <= 3; r++) begin drive(1, 0, 0, 1, r, 1, 0, 0); tick(); end
    drive(1, 0, 0, 1, 4, 1, 0, 0);
    checks++; if (stall !== 1'b1 || inflight !== 4'd3) begin errors++;
      $display("FAIL full_stall stall=%b inflight=%0d want 1 3", stall, inflight); end
    tick();
    drive(1, 0, 0, 1, 4, 1, 1, 1);
    checks++; if (stall !== 1'b1) begin errors++;
      $display("FAIL full_retire_same stall=%b want 1", stall); end
    tick();
    drive(1, 0, 0, 1, 4, 1, 0, 0);
    checks++; if (issue !== 1'b1 || inflight !== 4'd2) begin errors++;
      $display("FAIL full_release issue=%b inflight=%0d want 1 2", issue, inflight); end
    tick();
    checks++; if (inflight !== 4'd3 || pending !== 14'h001C) begin errors++;
      $display("FAIL full_after inflight=%0d pending=%h want 3 001c", inflight, pending); end
  endtask

  task automatic test_imm_untracked();
    do_reset();
    drive(1, 0, 0, 1, 5, 1, 0, 0); tick();
    drive(1, 0, 5, 1, 6, 1, 0, 0);
    checks++; if (issue !== 1'b1) begin errors++;
      $display("FAIL imm_bypass issue=%b want 1", issue); end
    tick();
    drive(1, 15, 14, 0, 14, 1, 0, 0);
    checks++; if (issue !== 1'b1) begin errors++;
      $display("FAIL untracked_issue issue=%b want 1", issue); end
    tick();
    checks++; if (pending !== 14'h0060 || inflight !== 4'd2) begin errors++;
      $display("FAIL untracked_state pending=%h inflight=%0d want 0060 2", pending, inflight); end
  endtask

  task automatic test_halt();
    do_reset();
    drive(1, 0, 0, 1, 7, 1, 0, 0); tick();
    halt_req = 1'b1;
    drive(0, 0, 0, 1, 0, 0, 0, 0); tick();
    drive(1, 0, 0, 1, 8, 1, 0, 0);
    checks++; if (issue !== 1'b0 || halted !== 1'b0) begin errors++;
      $display("FAIL drain_hold issue=%b halted=%b want 0 0", issue, halted); end
    tick();
    drive(0, 0, 0, 1, 0, 0, 1, 7); tick();
    checks++; if (halted !== 1'b0 || inflight !== 4'd0) begin errors++;
      $display("FAIL drain_retired halted=%b inflight=%0d want 0 0", halted, inflight); end
    drive(0, 0, 0, 1, 0, 0, 0, 0); tick();
    checks++; if (halted !== 1'b1) begin errors++;
      $display("FAIL halted_set got %b want 1", halted); end
    halt_req = 1'b0;
    drive(1, 0, 0, 1, 8, 1, 0, 0);
    checks++; if (issue !== 1'b0) begin errors++;
      $display("FAIL halted_no_issue issue=%b want 0", issue); end
    tick();
    drive(1, 0, 0, 1, 8, 1, 0, 0);
    checks++; if (halted !== 1'b0 || issue !== 1'b1) begin errors++;
      $display("FAIL resume halted=%b issue=%b want 0 1", halted, issue); end
    tick();
  endtask

  task automatic test_wb_err_stats();
    do_reset();
    drive(0, 0, 0, 1, 0, 0, 1, 9); tick();
    drive(0, 0, 0, 1, 0, 0, 0, 0); tick();
    checks++; if (wb_err !== 1'b1) begin errors++;
      $display("FAIL wb_err_sticky got %b want 1", wb_err); end
    drive(1, 0, 0, 1, 2, 1, 0, 0); tick();
    for (int i = 0; i < 5; i++) begin drive(1, 2, 0, 1, 0, 0, 0, 0); tick(); end
    drive(0, 0, 0, 1, 0, 0, 0, 0);
    checks++; if (32'(stall_cnt) !== m_stat()) begin errors++;
      $display("FAIL stall_cnt got %0d want %0d", stall_cnt, m_stat()); end
  endtask

  task automatic test_random();
    logic [3:0] w;
    do_reset();
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 24) == 0) halt_req = ~halt_req;
      w = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) != 0)
        for (int k = 0; k < 14; k++) if (m_pend[k] && $urandom_range(0, 1)) w = 4'(k);
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 15), $urandom_range(0, 15),
            $urandom_range(0, 1), $urandom_range(0, 15), $urandom_range(0, 3) != 0,
            $urandom_range(0, 2) == 0, w);
      checks++; if (issue !== m_issue() || stall !== (ins_valid && !m_issue())) begin
        errors++; $display("FAIL rnd_issue n=%0d issue=%b stall=%b want %b", n, issue, stall,
                           m_issue()); end
      checks++; if (pending !== m_vec() || 32'(inflight) !== m_count()) begin errors++;
        $display("FAIL rnd_sb n=%0d pending=%h inflight=%0d want %h %0d", n, pending,
                 inflight, m_vec(), m_count()); end
      checks++; if (halted !== (m_mode == 2) || wb_err !== m_err ||
                    32'(stall_cnt) !== m_stat()) begin errors++;
        $display("FAIL rnd_flags n=%0d halted=%b wb_err=%b stall_cnt=%0d want %b %b %0d", n,
                 halted, wb_err, stall_cnt, m_mode == 2, m_err, m_stat()); end
      tick();
    end
  endtask

  initial begin
    rst = 1'b1;
    test_reset();
    test_raw();
    test_full();
    test_imm_untracked();
    test_halt();
    test_wb_err_stats();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/issue_ctl.md
# issue_ctl

Pipeline issue/interlock controller for the CPU core. It holds a scoreboard of general registers r0–r13 that have a write in flight between Decode and Writeback. It gates each fetched instruction into the Decode stage only when its source and destination registers are free and the in-flight limit is not reached. It also provides a halt/drain sequence so the core can be quiesced with no writes outstanding.

## Interface
Parameters:
- MAX_INFLIGHT, 3, maximum outstanding tracked writes (1..14)
- CNT_W, 4, width of inflight counter (must hold MAX_INFLIGHT)

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- ins_valid  in  1  fetched instruction present at Decode input
- Ra  in  4  source A register index
- Rb  in  4  source B register index
- Imb  in  1  1 = B operand is immediate (Rb not read)
- Rc  in  4  destination register index
- wr_en  in  1  instruction writes Rc
- wb_valid  in  1  Writeback retiring a register write this cycle
- wb_rc  in  4  register index being retired
- halt_req  in  1  request to stop issuing and drain
- issue  out  1  Decode may latch this instruction this cycle
- stall  out  1  ins_valid high but issue low
- pending  out  14  scoreboard bit per r0..r13
- inflight  out  CNT_W  number of set pending bits
- halted  out  1  drain complete, no writes outstanding
- wb_err  out  1  sticky: retire of a non-pending register
- stall_cnt  out  16  stall cycle counter (see Configuration)

## Operation
- Tracked registers: indices 0..13. Index 14 (pc) and 15 (overflow) never stall a read; writes with Rc ≥ 14 set no bit and do not count.
- Hazard, combinational from registered state: RAW_A = pending[Ra] (Ra<14); RAW_B = ~Imb & pending[Rb] (Rb<14); WAW = wr_en & pending[Rc] (Rc<14); FULL = wr_en & Rc<14 & inflight == MAX_INFLIGHT.
- issue = ins_valid & state==RUN & ~(RAW_A|RAW_B|WAW|FULL); stall = ins_valid & ~issue.
- On issue & wr_en & Rc<14: pending[Rc] ← 1, inflight +1.
- On wb_valid & wb_rc<14 & pending[wb_rc]: clear bit, inflight −1. Both events in the same cycle (necessarily different registers, because WAW blocks the same register): net count unchanged.
- wb_valid to a clear bit or index ≥ 14 tracked: no state change. Clear bit (index<14) sets wb_err, which stays set until reset.
- No bypass: a reader of register X issues no earlier than the cycle after X's wb_valid.
- FSM states:
  - RUN: issue allowed; halt_req → DRAIN.
  - DRAIN: issue held 0; when inflight==0 → HALTED; halt_req drop → RUN.
  - HALTED: halted=1; halt_req drop → RUN.
  - halt_req with inflight already 0 still passes through one DRAIN cycle.

## Timing
- Reset (async): pending=0, inflight=0, state=RUN, wb_err=0, stall_cnt=0; so issue=ins_valid after reset, halted=0.
- issue/stall: zero latency (same cycle as inputs).
- pending/inflight: update at the edge ending the issue or retire cycle.
- halted: asserts on the first edge where DRAIN sees inflight==0 (≥1 cycle after halt_req). Deasserts on the edge after halt_req falls.
- rst mid-drain: all in-flight tracking lost, FSM to RUN. Writeback of those registers afterwards sets wb_err.

## Configuration
- ISSUE_CTL_STATS_EN defined: stall_cnt increments every cycle stall=1, saturates at 16'hFFFF, cleared only by rst.
- Not defined: stall_cnt tied to 0, no counter flops.

## Test plan
- Reset, ins_valid=1 Ra=1 Rb=2 Rc=3 wr_en=1 → issue=1; next cycle pending=14'h0008, inflight=1.
- Issue Rc=3, then Ra=3 → stall=1 until wb_valid wb_rc=3; issue=1 the cycle after retire; inflight back to 0.
- MAX_INFLIGHT=3: issue writes to r1,r2,r3, then Rc=4 → stall (FULL). Same-cycle retire r1 + stalled instruction: issues next cycle, inflight stays 3.
- Imb=1 Rb=5 with r5 pending → issue=1. Rc=14, Ra=15 → issue=1, pending unchanged.
- halt_req with r7 pending → DRAIN, issue=0; retire r7 → halted=1 next edge; drop halt_req → RUN, halted=0.
- wb_valid wb_rc=9 with r9 clear → wb_err=1 and sticky. With ISSUE_CTL_STATS_EN, 5 stalled cycles → stall_cnt=5.
